// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start, data LSB-first, [parity], stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DMAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    div, div_n;
  logic [BW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             tx_n;
  logic             done_n;
  logic             wrap;
`ifdef SERIAL_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign wrap  = (div == DMAX);
  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_comb begin
    state_n = state;
    div_n   = div;
    cnt_n   = cnt;
    shreg_n = shreg;
    tx_n    = tx;
    done_n  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = par;
`endif
    if (state != IDLE)
      div_n = wrap ? '0 : div + CW'(1);
    case (state)
      IDLE: begin
        if (load) begin
          state_n = START;
          shreg_n = din;
          tx_n    = 1'b0;
          div_n   = '0;
          cnt_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_n   = ^din;
`endif
        end
      end
      START: begin
        if (wrap) begin
          state_n = DATA;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
        end
      end
      DATA: begin
        if (wrap) begin
          if (cnt == BMAX) begin
            cnt_n = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            cnt_n   = cnt + BW'(1);
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (wrap) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (wrap) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      shreg <= '0;
      tx    <= 1'b1;
      done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      div   <= div_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      tx    <= tx_n;
      done  <= done_n;
`ifdef SERIAL_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed vector bench for serial_tx: CLKS_PER_BIT=1 table plus a
// hand-written CLKS_PER_BIT=3 frame.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       rst1, ld1;
  logic [7:0] d1;
  logic       rdy1, tx1, bsy1, dn1;
  logic       rst3, ld3;
  logic [7:0] d3;
  logic       rdy3, tx3, bsy3, dn3;

  int nvec = 0;
  int nmis = 0;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .reset(rst1), .din(d1), .load(ld1),
    .ready(rdy1), .tx(tx1), .busy(bsy1), .done(dn1)
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(3)) u3 (
    .clk(clk), .reset(rst3), .din(d3), .load(ld3),
    .ready(rdy3), .tx(tx3), .busy(bsy3), .done(dn3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] d;
    logic       tx;
    logic       rdy;
    logic       dn;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic l, input logic [7:0] d,
                     input logic t, input logic rdy, input logic dn);
    vec_t v;
    v.rst = r; v.ld = l; v.d = d;
    v.tx = t; v.rdy = rdy; v.dn = dn;
    vq.push_back(v);
  endtask

  // One full frame at one bit per clock; junk pulses load while busy.
  task automatic add_frame(input logic [7:0] w, input int junk,
                           input logic hold);
    add(0, 1, w, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(0, hold || (i == junk), 8'hFF, w[i-1], 0, 0);
    if (P == 1) add(0, hold, 8'hFF, ^w, 0, 0);
    add(0, hold, 8'hFF, 1, 0, 0);
    add(0, hold, 8'hFF, 1, 1, 1);
  endtask

  task automatic check(input string nm, input int idx,
                       input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s[%0d]: got %b want %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic [7:0] w3;
    logic       et;
    int         n3;
    int         b;
    vec_t       v;

    rst1 = 1; ld1 = 0; d1 = 0;
    rst3 = 1; ld3 = 0; d3 = 0;

    add(1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 1, 0);
    repeat (5) add(0, 0, 0, 1, 1, 0);
    add_frame(8'hA5, 4, 0);
    repeat (3) add(0, 0, 0, 1, 1, 0);
    add_frame(8'h07, 0, 0);
    add(0, 0, 0, 1, 1, 0);
    add_frame(8'h3C, 0, 1);
    add_frame(8'hC3, 0, 1);
    repeat (2) add(0, 0, 0, 1, 1, 0);
    add(0, 1, 8'hA5, 0, 0, 0);
    add(0, 0, 8'hFF, 1, 0, 0);
    add(0, 0, 8'hFF, 0, 0, 0);
    add(0, 0, 8'hFF, 1, 0, 0);
    add(0, 0, 8'hFF, 0, 0, 0);
    add(1, 0, 8'hFF, 1, 1, 0);
    add(0, 0, 8'hFF, 1, 1, 0);
    add_frame(8'h3C, 0, 0);
    repeat (2) add(0, 0, 0, 1, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      rst1 = v.rst; ld1 = v.ld; d1 = v.d;
      @(posedge clk);
      #1;
      check("tx1", i, tx1, v.tx);
      check("ready1", i, rdy1, v.rdy);
      check("busy1", i, bsy1, ~v.rdy);
      check("done1", i, dn1, v.dn);
    end
    @(negedge clk);
    ld1 = 0;

    repeat (2) begin
      @(posedge clk);
      #1;
      check("tx3_rst", 0, tx3, 1'b1);
      check("ready3_rst", 0, rdy3, 1'b1);
    end
    @(negedge clk);
    rst3 = 0;

    w3 = 8'h01;
    n3 = (10 + P) * 3;
    for (int e = 0; e <= n3 + 2; e++) begin
      @(negedge clk);
      ld3 = (e == 0);
      d3  = (e == 0) ? w3 : 8'hFF;
      @(posedge clk);
      #1;
      b = e / 3;
      if (e >= n3)          et = 1'b1;
      else if (b == 0)      et = 1'b0;
      else if (b <= 8)      et = w3[b-1];
      else if (P == 1 && b == 9) et = ^w3;
      else                  et = 1'b1;
      check("tx3", e, tx3, et);
      check("ready3", e, rdy3, e >= n3);
      check("done3", e, dn3, e == n3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
